// File: rtl/int_request_if.sv
// Bus bundle between the interrupt sources / CP0 side and the int_request
// front-end. The slave modport is the int_request view; the master modport
// is the view of whatever drives the raw lines and acknowledges handlers.
interface int_request_if #(
   parameter int CNT_WIDTH = 16
);
   logic [7:0]           raw_irq;
   logic [7:0]           edge_mode;
   logic                 ack_valid;
   logic [2:0]           ack_num;
   logic                 overrun_clr;
   logic [2:0]           stat_sel;
   logic [7:0]           hardware_interrupt;
   logic [7:0]           overrun;
   logic [CNT_WIDTH-1:0] stat_count;

   modport master (
      output raw_irq, edge_mode, ack_valid, ack_num, overrun_clr, stat_sel,
      input  hardware_interrupt, overrun, stat_count
   );

   modport slave (
      input  raw_irq, edge_mode, ack_valid, ack_num, overrun_clr, stat_sel,
      output hardware_interrupt, overrun, stat_count
   );
endinterface

// File: rtl/int_request.sv
// Interrupt request front-end feeding the CP0 hardware_interrupt input.
// Each of the eight raw lines is synchronised (2 flops), debounced, and then
// either latched on its rising edge until CP0 acknowledges the handler
// (edge mode) or passed through as a level (level mode). A rising edge that
// arrives while the previous request is still pending sets a sticky overrun.
// An ack on the same edge as a new rise consumes the old request and keeps
// the new one, so that case is not an overrun.
// Optional: define INT_REQ_STAT_EN to add saturating per-line counters of
// edge-mode rises, readable through stat_sel/stat_count. Without it the
// counters are absent and stat_count is tied to zero.
module int_request #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 16
) (
   input logic          clk,
   input logic          clr,
   int_request_if.slave bus
);

   // Debounce counter width; kept at least 1 bit so the no-debounce build
   // still has legal (unused) counter declarations.
   localparam int DBW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic [7:0]          s1_q, s2_q;
   logic [7:0]          stable_q, stable_d;
   logic [7:0][DBW-1:0] db_cnt_q, db_cnt_d;
   logic [7:0]          pending_q, pending_d;
   logic [7:0]          overrun_q, overrun_d;
   logic [7:0]          rise;
   logic [7:0]          ack_hit;
   logic [7:0]          ovr_set;

   // Two-flop synchroniser for the asynchronous raw lines.
   always_ff @(posedge clk) begin
      if (clr) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= bus.raw_irq;
         s2_q <= s1_q;
      end
   end

   // Debounce: a new synchronised value must hold for DEBOUNCE_CYCLES edges.
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = '0;
      for (int n = 0; n < 8; n++) begin
         if (DEBOUNCE_CYCLES == 0) begin
            stable_d[n] = s2_q[n];
         end else if (s2_q[n] != stable_q[n]) begin
            if (db_cnt_q[n] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               stable_d[n] = s2_q[n];
            end else begin
               db_cnt_d[n] = db_cnt_q[n] + DBW'(1);
            end
         end
      end
   end

   // Request latching, acknowledge and overrun detection.
   always_comb begin
      rise      = stable_d & ~stable_q;
      ack_hit   = bus.ack_valid ? (8'b1 << bus.ack_num) : 8'b0;
      pending_d = (bus.edge_mode & (rise | (pending_q & ~ack_hit)))
                | (~bus.edge_mode & stable_d);
      ovr_set   = bus.edge_mode & rise & pending_q & ~ack_hit;
      overrun_d = (overrun_q & ~{8{bus.overrun_clr}}) | ovr_set;
   end

   // Debounce, pending and overrun state registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         stable_q  <= '0;
         db_cnt_q  <= '0;
         pending_q <= '0;
         overrun_q <= '0;
      end else begin
         stable_q  <= stable_d;
         db_cnt_q  <= db_cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.hardware_interrupt = pending_q;
   assign bus.overrun            = overrun_q;

`ifdef INT_REQ_STAT_EN
   logic [7:0][CNT_WIDTH-1:0] stat_q, stat_d;

   // Saturating count of edge-mode rises per line.
   always_comb begin
      stat_d = stat_q;
      for (int n = 0; n < 8; n++) begin
         if (bus.edge_mode[n] && rise[n] && (stat_q[n] != '1)) begin
            stat_d[n] = stat_q[n] + CNT_WIDTH'(1);
         end
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign bus.stat_count = stat_q[bus.stat_sel];
`else
   assign bus.stat_count = '0;
`endif

endmodule

// File: tb/tb_int_request.sv
// Directed bench for int_request with DEBOUNCE_CYCLES=4. Expected values are
// queued when the stimulus is driven and popped at each check point.
module tb_int_request;

   localparam int W = 16;

   logic clk;
   logic clr;

   int_request_if #(.CNT_WIDTH(W)) bus ();

   int_request #(
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH      (W)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Scoreboard.
   logic [W-1:0] exp_q[$];
   int compared   = 0;
   int mismatched = 0;

   task automatic push(input logic [W-1:0] v);
      exp_q.push_back(v);
   endtask

   task automatic cmp(input string tag, input logic [W-1:0] obs);
      logic [W-1:0] exp;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack(input logic [2:0] num);
      bus.ack_valid = 1'b1;
      bus.ack_num   = num;
      step(1);
      bus.ack_valid = 1'b0;
   endtask

   initial begin
      clr             = 1'b1;
      bus.raw_irq     = '0;
      bus.edge_mode   = 8'hFF;
      bus.ack_valid   = 1'b0;
      bus.ack_num     = '0;
      bus.overrun_clr = 1'b0;
      bus.stat_sel    = '0;

      // Reset state.
      step(2);
      clr = 1'b0;
      push(16'h0000); cmp("reset_hw", W'(bus.hardware_interrupt));
      push(16'h0000); cmp("reset_ovr", W'(bus.overrun));
      push(16'h0000); cmp("reset_stat", bus.stat_count);

      // Line 3 edge latch: high after edge k+5, held until ack.
      bus.raw_irq[3] = 1'b1;
      push(16'h0000); push(16'h0008); push(16'h0008); push(16'h0000);
      step(5);  cmp("l3_before_latency", W'(bus.hardware_interrupt));
      step(1);  cmp("l3_latched", W'(bus.hardware_interrupt));
      bus.raw_irq[3] = 1'b0;
      step(10); cmp("l3_held_raw_low", W'(bus.hardware_interrupt));
      ack(3'd3); cmp("l3_after_ack", W'(bus.hardware_interrupt));

      // Ack on a line that is not pending does nothing.
      ack(3'd6);
      push(16'h0000); cmp("ack_not_pending", W'(bus.hardware_interrupt));

      // Three-cycle glitch on line 5 is filtered.
      bus.raw_irq[5] = 1'b1;
      step(3);
      bus.raw_irq[5] = 1'b0;
      step(10);
      push(16'h0000); cmp("glitch_hw", W'(bus.hardware_interrupt));
      push(16'h0000); cmp("glitch_ovr", W'(bus.overrun));

      // Line 2: second rise while pending sets overrun.
      bus.raw_irq[2] = 1'b1;
      step(6);
      push(16'h0004); cmp("l2_first", W'(bus.hardware_interrupt));
      bus.raw_irq[2] = 1'b0;
      step(8);
      bus.raw_irq[2] = 1'b1;
      step(6);
      push(16'h0004); cmp("l2_second_hw", W'(bus.hardware_interrupt));
      push(16'h0004); cmp("l2_overrun", W'(bus.overrun));
      bus.overrun_clr = 1'b1;
      step(1);
      bus.overrun_clr = 1'b0;
      push(16'h0000); cmp("overrun_clr", W'(bus.overrun));
      bus.raw_irq[2] = 1'b0;
      ack(3'd2);
      push(16'h0000); cmp("l2_acked", W'(bus.hardware_interrupt));
      step(8);

      // Line 0: rise and ack on the same edge keeps pending, no overrun.
      bus.raw_irq[0] = 1'b1;
      step(6);
      push(16'h0001); cmp("l0_first", W'(bus.hardware_interrupt));
      bus.raw_irq[0] = 1'b0;
      step(8);
      bus.raw_irq[0] = 1'b1;
      step(5);
      ack(3'd0);
      push(16'h0001); cmp("l0_rise_ack_hw", W'(bus.hardware_interrupt));
      push(16'h0000); cmp("l0_rise_ack_ovr", W'(bus.overrun));
      bus.raw_irq[0] = 1'b0;
      ack(3'd0);
      push(16'h0000); cmp("l0_cleared", W'(bus.hardware_interrupt));
      step(8);

      // Line 7 in level mode, ack ignored.
      bus.edge_mode[7] = 1'b0;
      bus.raw_irq[7]   = 1'b1;
      step(5);
      push(16'h0000); cmp("l7_before_latency", W'(bus.hardware_interrupt));
      step(1);
      push(16'h0080); cmp("l7_level_high", W'(bus.hardware_interrupt));
      ack(3'd7);
      push(16'h0080); cmp("l7_ack_ignored", W'(bus.hardware_interrupt));
      step(3);
      bus.raw_irq[7] = 1'b0;
      step(5);
      push(16'h0080); cmp("l7_before_fall", W'(bus.hardware_interrupt));
      step(1);
      push(16'h0000); cmp("l7_level_low", W'(bus.hardware_interrupt));
      push(16'h0000); cmp("l7_no_overrun", W'(bus.overrun));

      // Three rises on line 1, never acked.
      for (int i = 0; i < 3; i++) begin
         bus.raw_irq[1] = 1'b1;
         step(6);
         bus.raw_irq[1] = 1'b0;
         step(8);
      end
      push(16'h0002); cmp("l1_pending", W'(bus.hardware_interrupt));
      push(16'h0002); cmp("l1_overrun", W'(bus.overrun));
      bus.stat_sel = 3'd1;
      #1;
`ifdef INT_REQ_STAT_EN
      push(16'd3);
`else
      push(16'd0);
`endif
      cmp("stat_line1", bus.stat_count);
      bus.stat_sel = 3'd0;
      #1;
`ifdef INT_REQ_STAT_EN
      push(16'd2);
`else
      push(16'd0);
`endif
      cmp("stat_line0", bus.stat_count);

      // Reset mid-stream with line 1 high and mid-debounce.
      bus.stat_sel   = 3'd1;
      bus.raw_irq[1] = 1'b1;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      push(16'h0000); cmp("clr_hw", W'(bus.hardware_interrupt));
      push(16'h0000); cmp("clr_ovr", W'(bus.overrun));
      push(16'h0000); cmp("clr_stat", bus.stat_count);

      // A line held high through reset is a new rise afterwards.
      step(5);
      push(16'h0000); cmp("post_clr_latency", W'(bus.hardware_interrupt));
      step(1);
      push(16'h0002); cmp("post_clr_rise", W'(bus.hardware_interrupt));
`ifdef INT_REQ_STAT_EN
      push(16'd1);
`else
      push(16'd0);
`endif
      cmp("post_clr_stat", bus.stat_count);

      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $error("FAIL scoreboard_drain: observed %0d left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/int_request.md
Name: int_request

Overview:
- Interrupt request front-end that sits directly upstream of the CP0 interrupt controller. It drives that controller's 8-bit hardware_interrupt input.
- Synchronises, debounces and latches eight raw device/button lines.
- Per line: edge-latched or level mode.
- Clears latched requests when CP0 acknowledges entry into the corresponding handler.
- Flags requests lost because a new edge arrived while the previous one was still pending.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised line must hold a new value before it is accepted; 0 = no debounce.
- CNT_WIDTH, 16: width of the per-line statistics counters (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  reset, synchronous, active-high.
- raw_irq  in  8  asynchronous raw request lines; bit n = interrupt n, 7 highest priority.
- edge_mode  in  8  per line: 1 = latch on rising edge until ack; 0 = level (follows debounced line).
- ack_valid  in  1  CP0 entered a handler this cycle.
- ack_num  in  3  interrupt number being entered.
- overrun_clr  in  1  clears all overrun flags.
- stat_sel  in  3  line selected for stat_count.
- hardware_interrupt  out  8  registered request vector to CP0.
- overrun  out  8  sticky lost-request flags.
- stat_count  out  CNT_WIDTH  pending-set event count of line stat_sel.

Behaviour:
- Reset (clr=1 at posedge): synchronisers, debounce counters, stable state, pending, overrun and stats all go to 0. hardware_interrupt=0, overrun=0, stat_count=0. Same result when clr asserts mid-operation.
- After reset, a raw line already held high is seen as a new rising edge once it passes the sync and debounce stages.
- Sync: two flops per line, s1<=raw, s2<=s1.
- Debounce, per line:
  - State: stable bit plus a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If s2==stable, counter<=0.
  - Otherwise counter increments. At the edge where it would reach DEBOUNCE_CYCLES: stable<=s2 and counter<=0.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach stable.
  - DEBOUNCE_CYCLES=0: stable<=s2 every edge.
- rise[n]: asserted on the edge where stable[n] transitions 0->1.
- Edge mode, same posedge:
  - rise sets pending.
  - ack_valid && ack_num==n clears pending.
  - rise and ack on the same line together: pending stays 1 and no overrun is flagged.
  - rise while pending=1 with no matching ack: pending stays 1 and overrun[n]<=1.
- Level mode: pending[n] <= stable[n]; ack ignored; overrun never set.
- edge_mode change: takes effect on the next edge. A line switched to level mode drops or raises pending per stable on that edge.
- hardware_interrupt = pending (register output, no combinational path from inputs).
- Latency:
  - Raw rise first sampled at edge k gives rise[n] at edge k+DEBOUNCE_CYCLES+1, with hardware_interrupt high after that edge.
  - Ack takes effect at the same edge, so hardware_interrupt is low the cycle after the ack.
- overrun_clr clears all overrun bits. A simultaneous new overrun on line n wins for that bit.
- ack on a line that is not pending: no effect.

Optional Feature:
- INT_REQ_STAT_EN defined:
  - Eight CNT_WIDTH counters, each incrementing on every rise of its line in edge mode.
  - Counters saturate at all-ones and are cleared by clr.
  - stat_count = counter[stat_sel], combinational read.
- INT_REQ_STAT_EN undefined:
  - No counters are synthesised.
  - stat_count tied to 0; stat_sel ignored.

Test Plan:
- DEBOUNCE_CYCLES=4, edge_mode=8'hFF, raw_irq[3] rises, first sampled at edge k -> hardware_interrupt=8'h08 after edge k+5. It stays high with raw low until ack_valid=1, ack_num=3; then 8'h00 the next cycle.
- raw_irq[5] glitch high for 3 cycles, DEBOUNCE_CYCLES=4 -> hardware_interrupt stays 8'h00; overrun stays 8'h00.
- Line 2 pending, second debounced rise with no ack -> overrun=8'h04, hardware_interrupt[2]=1. overrun_clr -> overrun=8'h00.
- rise and ack on line 0 on the same edge -> hardware_interrupt[0]=1 after that edge, overrun[0]=0.
- edge_mode[7]=0, raw_irq[7] high for 10 cycles then low -> hardware_interrupt[7] high from k+5 and low 5 edges after the fall is sampled; ack_valid with ack_num=7 while high has no effect.
- INT_REQ_STAT_EN: three rises on line 1, stat_sel=1 -> stat_count=3. clr mid-stream -> all outputs 0 next cycle. Without INT_REQ_STAT_EN -> stat_count=0.
